// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings and IR field helpers for the control sequencer
package control_pkg;

    // Instruction sequencing states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Bus source codes
    localparam int SRC_ZERO = 0;
    localparam int SRC_IMM  = 1;
    localparam int SRC_A    = 2;
    localparam int SRC_B    = 3;
    localparam int SRC_X    = 4;
    localparam int SRC_RAM  = 5;
    localparam int SRC_ALU  = 6;

    // Load destination codes; 0 and 1 have no register behind them
    localparam int DST_FIRST = 2;
    localparam int DST_A     = 2;
    localparam int DST_B     = 3;
    localparam int DST_X     = 4;
    localparam int DST_RAM   = 5;
    localparam int DST_Q     = 6;
    localparam int DST_PC    = 7;

    // Jump condition codes, formed as {b7, b3}
    localparam int COND_ALWAYS = 0;
    localparam int COND_ZERO   = 1;
    localparam int COND_CARRY  = 2;
    localparam int COND_SHIFT  = 3;

    // IR layout is {b7, dest[DSEL-1:0], b3, src[SSEL-1:0]}
    function automatic int ir_b3_pos(input int ssel);
        return ssel;
    endfunction

    function automatic int ir_dst_lsb(input int ssel);
        return ssel + 1;
    endfunction

    function automatic int ir_b7_pos(input int dsel, input int ssel);
        return dsel + ssel + 1;
    endfunction

endpackage

// File: rtl/control_seq_cond_select.sv
// rtl/control_seq_cond_select.sv - jump condition mux with always-true slot 0
module cond_select
    import control_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [1:0] i_cond,
    output logic       o_take_jump
);

    // flags[0] has no meaning: slot 0 is the unconditional jump
    logic w_unused_flag0;
    assign w_unused_flag0 = i_flags[0];

    // Select the addressed flag, or force taken for the unconditional code
    always_comb begin
        o_take_jump = 1'b0;
        if (i_cond == 2'(COND_ALWAYS)) begin
            o_take_jump = 1'b1;
        end else begin
            o_take_jump = i_flags[i_cond];
        end
    end

endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - clocked FETCH/EXEC/HALT control sequencer with load strobes
module control_seq
    import control_pkg::*;
#(
    parameter int DSEL = 3,
    parameter int SSEL = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2+DSEL+SSEL-1:0] ir_in,
    input  logic [3:0]            flags,
    input  logic                  mem_ready,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [2**DSEL-1:0]    load_en,
    output logic [2**SSEL-1:0]    src_oe,
    output logic                  mem_req,
    output logic                  alu_sub,
    output logic                  alu_cin,
    output logic                  halted
);

    localparam int IRW  = 2 + DSEL + SSEL;
    localparam int NDST = 2 ** DSEL;
    localparam int NSRC = 2 ** SSEL;

    state_t            r_state;
    state_t            w_next;
    logic [IRW-1:0]    r_ir;

    logic [SSEL-1:0]   w_src;
    logic [DSEL-1:0]   w_dst;
    logic              w_b3;
    logic              w_b7;
    logic              w_take;
    logic              w_is_ram;
    logic              w_is_jump;
    logic              w_is_imm;
    logic              w_is_halt;
    logic              w_strobe;
    logic [NDST-1:0]   w_dst_oh;
    logic [NSRC-1:0]   w_src_oh;

    assign w_src     = r_ir[SSEL-1:0];
    assign w_b3      = r_ir[ir_b3_pos(SSEL)];
    assign w_dst     = r_ir[ir_dst_lsb(SSEL) +: DSEL];
    assign w_b7      = r_ir[ir_b7_pos(DSEL, SSEL)];

    assign w_is_ram  = (w_src == SSEL'(SRC_RAM)) || (w_dst == DSEL'(DST_RAM));
    assign w_is_jump = (w_dst == DSEL'(DST_PC));
    assign w_is_imm  = (w_src == SSEL'(SRC_IMM));
    assign w_is_halt = (r_ir == '0);
    // RAM instructions hold until the access completes; everything else strobes at once
    assign w_strobe  = !w_is_ram || mem_ready;

    cond_select u_cond_select (
        .i_flags     (flags),
        .i_cond      ({w_b7, w_b3}),
        .o_take_jump (w_take)
    );

    // One-hot decode of dest (codes 0/1 never decoded) and src fields
    always_comb begin
        w_dst_oh = '0;
        w_src_oh = '0;
        for (int i = DST_FIRST; i < NDST; i++) begin
            w_dst_oh[i] = (w_dst == DSEL'(i));
        end
        for (int j = 0; j < NSRC; j++) begin
            w_src_oh[j] = (w_src == SSEL'(j));
        end
    end

    // State and instruction register; IR captured at the end of FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH) begin
                r_ir <= ir_in;
            end
        end
    end

    // Next state and strobes; reset forces every output low
    always_comb begin
        w_next  = r_state;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        load_en = '0;
        src_oe  = '0;
        mem_req = 1'b0;
        alu_sub = 1'b0;
        alu_cin = 1'b0;
        halted  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = ST_EXEC;
                end
                ST_EXEC: begin
                    src_oe  = w_src_oh;
                    alu_sub = w_b3;
                    alu_cin = w_b7;
                    mem_req = w_is_ram;
                    if (w_is_halt) begin
                        w_next = ST_HALT;
                    end else if (w_strobe) begin
                        w_next  = ST_FETCH;
                        // a taken jump replaces the immediate-consuming increment
                        pc_load = w_is_jump && w_take;
                        pc_inc  = w_is_imm && !(w_is_jump && w_take);
                        if (!w_is_jump || w_take) begin
                            load_en = w_dst_oh;
                        end
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - randomized self-checking bench for control_seq
module tb_control_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ir_in;
    logic [3:0]  flags;
    logic        mem_ready;
    logic        ir_load, pc_inc, pc_load, mem_req, alu_sub, alu_cin, halted;
    logic [7:0]  load_en, src_oe;
    logic [22:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [22:0] FETCH_V = 23'h600000;
    localparam logic [22:0] HALT_V  = 23'h010000;

    control_seq #(.DSEL(3), .SSEL(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_in     (ir_in),
        .flags     (flags),
        .mem_ready (mem_ready),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .load_en   (load_en),
        .src_oe    (src_oe),
        .mem_req   (mem_req),
        .alu_sub   (alu_sub),
        .alu_cin   (alu_cin),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    assign w_obs = {ir_load, pc_inc, pc_load, mem_req, alu_sub, alu_cin, halted, load_en, src_oe};

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected EXEC-cycle outputs computed straight from the instruction rules
    function automatic logic [22:0] exp_exec(input int ir, input logic [3:0] fl, input bit ready);
        int src, dst, b3, b7, cond;
        bit ram, jmp, take, go;
        logic [7:0] ld, oe;
        bit p_inc, p_load;
        src  = ir % 8;
        b3   = (ir / 8) % 2;
        dst  = (ir / 16) % 8;
        b7   = ir / 128;
        ram  = (src == 5) || (dst == 5);
        jmp  = (dst == 7);
        cond = b7 * 2 + b3;
        take = (cond == 0) || (fl[cond] == 1'b1);
        go   = !ram || ready;
        p_load = go && jmp && take;
        p_inc  = go && (src == 1) && !(jmp && take);
        ld = (go && dst >= 2 && (!jmp || take)) ? 8'(1 << dst) : 8'h00;
        oe = 8'(1 << src);
        return {1'b0, p_inc, p_load, ram, b3[0], b7[0], 1'b0, ld, oe};
    endfunction

    task automatic do_fetch(input logic [7:0] ir);
        ir_in     = ir;
        flags     = 4'($urandom);
        mem_ready = 1'($urandom);
        #1 check("fetch", w_obs, FETCH_V);
        @(negedge clk);
        ir_in = 8'($urandom);
    endtask

    task automatic do_exec(input logic [7:0] ir, input int waits, input logic [3:0] fl);
        for (int w = 0; w < waits; w++) begin
            flags     = 4'($urandom);
            mem_ready = 1'b0;
            #1 check("stall", w_obs, exp_exec(int'(ir), flags, 1'b0));
            @(negedge clk);
        end
        flags     = fl;
        mem_ready = 1'b1;
        #1 check("exec", w_obs, exp_exec(int'(ir), fl, 1'b1));
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        reset     = 1'b1;
        mem_ready = 1'b1;
        flags     = 4'hF;
        for (int c = 0; c < 2; c++) begin
            #1 check("rst_hold", w_obs, 23'h0);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    logic [7:0] d_ir [6] = '{8'h23, 8'h31, 8'h52, 8'h79, 8'h79, 8'hF9};
    int         d_wt [6] = '{0, 0, 3, 0, 0, 0};
    logic [3:0] d_fl [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h2, 4'h8};

    initial begin
        reset     = 1'b1;
        ir_in     = 8'h00;
        flags     = 4'h0;
        mem_ready = 1'b0;
        @(negedge clk);
        #1 check("rst_init", w_obs, 23'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset while 0x52 stalls in EXEC, then confirm a clean FETCH
        do_fetch(8'h52);
        mem_ready = 1'b0;
        #1 check("stall_pre_rst", w_obs, exp_exec(32'h52, flags, 1'b0));
        reset_pulse();

        for (int k = 0; k < 6; k++) begin
            do_fetch(d_ir[k]);
            do_exec(d_ir[k], d_wt[k], d_fl[k]);
        end

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ir;
            int         wt;
            ir = 8'($urandom_range(1, 255));
            wt = ((ir % 8 == 5) || ((ir / 16) % 8 == 5)) ? int'($urandom_range(0, 3)) : 0;
            do_fetch(ir);
            do_exec(ir, wt, 4'($urandom));
        end

        // HALT holds until reset, then sequencing resumes
        do_fetch(8'h00);
        do_exec(8'h00, 0, 4'($urandom));
        for (int c = 0; c < 3; c++) begin
            flags     = 4'($urandom);
            mem_ready = 1'($urandom);
            #1 check("halt", w_obs, HALT_V);
            @(negedge clk);
        end
        reset_pulse();
        do_fetch(8'h23);
        do_exec(8'h23, 0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
